mem_store_forward_buffer: RTL and testbench

Parametrised store buffer with store-to-load forwarding. It sits between the MEM stage and data memory and succeeds the single-entry combinational memory forward check. It queues up to DEPTH pending stores and retires them to memory under a busywait handshake. Loads read the newest matching store from the buffer in the same cycle, or stall when a partial-byte overlap cannot be resolved.

---
 rtl/mem_store_forward_buffer.sv | 128 ++++++++++++
 tb/tb_mem_store_forward_buffer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_store_forward_buffer.sv
// Store buffer with newest-match store-to-load forwarding, drained in order to memory.
// Optional byte-merging of stores into the tail entry: define MEM_FWD_COALESCE_EN.
module mem_store_forward_buffer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          STORE_VALID,
    input  logic [ADDR_WIDTH-1:0]         STORE_ADDR,
    input  logic [DATA_WIDTH-1:0]         STORE_DATA,
    input  logic [DATA_WIDTH/8-1:0]       STORE_MASK,
    output logic                          STORE_READY,
    input  logic                          LOAD_VALID,
    input  logic [ADDR_WIDTH-1:0]         LOAD_ADDR,
    output logic                          FWD_HIT,
    output logic [DATA_WIDTH-1:0]         FWD_DATA,
    output logic                          LOAD_STALL,
    output logic                          MEM_WRITE,
    output logic [ADDR_WIDTH-1:0]         MEM_ADDR,
    output logic [DATA_WIDTH-1:0]         MEM_WRITEDATA,
    output logic [DATA_WIDTH/8-1:0]       MEM_MASK,
    input  logic                          MEM_BUSYWAIT,
    output logic [$clog2(DEPTH+1)-1:0]    COUNT,
    output logic                          EMPTY
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFF   = $clog2(BYTES);
    localparam int WAW   = ADDR_WIDTH - OFF;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);

    logic [WAW-1:0]        ent_addr [DEPTH];
    logic [DATA_WIDTH-1:0] ent_data [DEPTH];
    logic [BYTES-1:0]      ent_mask [DEPTH];

    logic [PW-1:0]  head, tail, idx, sel;
    logic [CW-1:0]  count;
    logic           empty, push, pop, merge_ok, found, sel_full;
    logic [WAW-1:0] store_wa, load_wa;

    assign store_wa = STORE_ADDR[ADDR_WIDTH-1:OFF];
    assign load_wa  = LOAD_ADDR[ADDR_WIDTH-1:OFF];

    generate
        if (OFF > 0) begin : g_unused_offsets
            logic unused_offsets;
            assign unused_offsets = ^{STORE_ADDR[OFF-1:0], LOAD_ADDR[OFF-1:0]};
        end
    endgenerate

    assign empty = (count == '0);

`ifdef MEM_FWD_COALESCE_EN
    logic [PW-1:0] last;
    assign last = tail - PW'(1);
    // With one entry the tail-most entry is the head, which is always on the memory port.
    assign merge_ok = (count > CW'(1)) && (ent_addr[last] == store_wa);
`else
    assign merge_ok = 1'b0;
`endif

    // Handshakes: a store transfers at a rising edge where STORE_VALID && STORE_READY;
    // the head retires at a rising edge where MEM_WRITE && !MEM_BUSYWAIT.
    assign STORE_READY = (count < CW'(DEPTH)) || merge_ok;
    assign push        = STORE_VALID && STORE_READY && !merge_ok;
    assign pop         = !empty && !MEM_BUSYWAIT;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry payload needs no reset: it is only observed through count-qualified logic.
    always_ff @(posedge CLK) begin
        if (push) begin
            ent_addr[tail] <= store_wa;
            ent_data[tail] <= STORE_DATA;
            ent_mask[tail] <= STORE_MASK;
        end
`ifdef MEM_FWD_COALESCE_EN
        if (STORE_VALID && merge_ok) begin
            for (int b = 0; b < BYTES; b++) begin
                if (STORE_MASK[b]) ent_data[last][8*b +: 8] <= STORE_DATA[8*b +: 8];
            end
            ent_mask[last] <= ent_mask[last] | STORE_MASK;
        end
`endif
    end

    // Walk oldest to newest so the last match seen is the newest one.
    always_comb begin
        found = 1'b0;
        sel   = head;
        idx   = head;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if ((CW'(i) < count) && (ent_addr[idx] == load_wa)) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    assign sel_full   = &ent_mask[sel];
    assign FWD_HIT    = LOAD_VALID && found && sel_full;
    assign LOAD_STALL = LOAD_VALID && found && !sel_full;
    assign FWD_DATA   = FWD_HIT ? ent_data[sel] : '0;

    assign MEM_WRITE     = !empty;
    assign MEM_ADDR      = empty ? '0 : (ADDR_WIDTH'(ent_addr[head]) << OFF);
    assign MEM_WRITEDATA = empty ? '0 : ent_data[head];
    assign MEM_MASK      = empty ? '0 : ent_mask[head];
    assign COUNT         = count;
    assign EMPTY         = empty;
endmodule

// File: tb/tb_mem_store_forward_buffer.sv
// Bench for mem_store_forward_buffer: directed scenarios plus random traffic against a
// queue-based model of pending stores; load and retire results go through a scoreboard.
module tb_mem_store_forward_buffer;
    localparam int DEPTH = 4;
`ifdef MEM_FWD_COALESCE_EN
    localparam bit COALESCE = 1'b1;
`else
    localparam bit COALESCE = 1'b0;
`endif

    logic        CLK, RESET;
    logic        STORE_VALID, STORE_READY, LOAD_VALID, FWD_HIT, LOAD_STALL;
    logic        MEM_WRITE, MEM_BUSYWAIT, EMPTY;
    logic [31:0] STORE_ADDR, STORE_DATA, LOAD_ADDR, FWD_DATA, MEM_ADDR, MEM_WRITEDATA;
    logic [3:0]  STORE_MASK, MEM_MASK;
    logic [2:0]  COUNT;

    mem_store_forward_buffer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RESET(RESET),
        .STORE_VALID(STORE_VALID), .STORE_ADDR(STORE_ADDR), .STORE_DATA(STORE_DATA),
        .STORE_MASK(STORE_MASK), .STORE_READY(STORE_READY),
        .LOAD_VALID(LOAD_VALID), .LOAD_ADDR(LOAD_ADDR),
        .FWD_HIT(FWD_HIT), .FWD_DATA(FWD_DATA), .LOAD_STALL(LOAD_STALL),
        .MEM_WRITE(MEM_WRITE), .MEM_ADDR(MEM_ADDR), .MEM_WRITEDATA(MEM_WRITEDATA),
        .MEM_MASK(MEM_MASK), .MEM_BUSYWAIT(MEM_BUSYWAIT),
        .COUNT(COUNT), .EMPTY(EMPTY)
    );

    // ---------------- clock / reset ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- model and scoreboard state ----------------
    typedef struct {
        logic [29:0] wa;
        logic [31:0] data;
        logic [3:0]  mask;
    } ent_t;

    ent_t        buf_q[$];        // pending stores, oldest first
    logic [67:0] mem_exp_q[$];    // {addr, data, mask} expected on retire
    logic [33:0] ld_exp_q[$];     // {stall, hit, data} expected per load
    int          checks = 0;
    int          failures = 0;

    task automatic check(input string name, input logic [67:0] act, input logic [67:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [33:0] ld_model(input logic [31:0] la);
        for (int i = buf_q.size() - 1; i >= 0; i--) begin
            if (buf_q[i].wa == la[31:2])
                return (buf_q[i].mask == 4'hF) ? {2'b01, buf_q[i].data} : {2'b10, 32'h0};
        end
        return '0;
    endfunction

    function automatic bit can_merge(input logic [31:0] sa);
        bit m;
        m = (buf_q.size() >= 2) && (buf_q[buf_q.size()-1].wa == sa[31:2]);
        return COALESCE && m;
    endfunction

    function automatic logic [35:0] merge_ent(input logic [3:0] om, input logic [31:0] od,
                                              input logic [3:0] nm, input logic [31:0] nd);
        logic [31:0] d;
        d = od;
        for (int b = 0; b < 4; b++) if (nm[b]) d[8*b +: 8] = nd[8*b +: 8];
        return {om | nm, d};
    endfunction

    task automatic idle_inputs();
        STORE_VALID  = 1'b0;
        STORE_ADDR   = '0;
        STORE_DATA   = '0;
        STORE_MASK   = '0;
        LOAD_VALID   = 1'b0;
        LOAD_ADDR    = '0;
        MEM_BUSYWAIT = 1'b1;
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                        input logic [3:0] sm, input logic lv, input logic [31:0] la,
                        input logic busy);
        bit          acc, mrg;
        int          n;
        logic [35:0] r;
        logic [67:0] e;
        @(negedge CLK);
        STORE_VALID = sv; STORE_ADDR = sa; STORE_DATA = sd; STORE_MASK = sm;
        LOAD_VALID = lv; LOAD_ADDR = la; MEM_BUSYWAIT = busy;
        #1;
        mrg = can_merge(sa);
        n   = buf_q.size();
        check("count", COUNT, n);
        check("empty", EMPTY, n == 0);
        check("store_ready", STORE_READY, (n < DEPTH) || mrg);
        check("mem_write", MEM_WRITE, n != 0);
        if (lv) ld_exp_q.push_back(ld_model(la));
        else check("idle_load", {LOAD_STALL, FWD_HIT, FWD_DATA}, 0);
        acc = sv && ((n < DEPTH) || mrg);
        if (acc && mrg) begin
            e = mem_exp_q[mem_exp_q.size()-1];
            r = merge_ent(e[3:0], e[35:4], sm, sd);
            mem_exp_q[mem_exp_q.size()-1] = {e[67:36], r[31:0], r[35:32]};
        end else if (acc) begin
            mem_exp_q.push_back({sa & 32'hFFFF_FFFC, sd, sm});
        end
        @(posedge CLK);
        if (buf_q.size() > 0 && !busy) void'(buf_q.pop_front());
        if (acc && mrg) begin
            n = buf_q.size() - 1;
            r = merge_ent(buf_q[n].mask, buf_q[n].data, sm, sd);
            buf_q[n].mask = r[35:32];
            buf_q[n].data = r[31:0];
        end else if (acc) begin
            buf_q.push_back('{wa: sa[31:2], data: sd, mask: sm});
        end
        #1 idle_inputs();
    endtask

    // Asynchronous reset in the middle of a cycle; outputs must clear at once.
    task automatic reset_mid();
        @(negedge CLK);
        #3 RESET = 1'b0;
        #1;
        check("rst_mem_write", MEM_WRITE, 0);
        check("rst_count", COUNT, 0);
        check("rst_empty", EMPTY, 1);
        check("rst_ready", STORE_READY, 1);
        check("rst_mem_bus", {MEM_ADDR, MEM_WRITEDATA, MEM_MASK}, 0);
        buf_q.delete();
        mem_exp_q.delete();
        ld_exp_q.delete();
        @(negedge CLK);
        #3 RESET = 1'b1;
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [67:0] e;
        forever begin
            @(negedge CLK);
            #2;
            if (RESET) begin
                if (LOAD_VALID) begin
                    if (ld_exp_q.size() == 0) check("load_unexpected", 1, 0);
                    else check("load", {LOAD_STALL, FWD_HIT, FWD_DATA}, ld_exp_q.pop_front());
                end
                if (MEM_WRITE && !MEM_BUSYWAIT) begin
                    if (mem_exp_q.size() == 0) check("retire_unexpected", 1, 0);
                    else begin
                        e = mem_exp_q.pop_front();
                        check("retire", {MEM_ADDR, MEM_WRITEDATA, MEM_MASK}, e);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a;
        idle_inputs();
        RESET = 1'b0;
        #2;
        check("reset_state", {COUNT, EMPTY, STORE_READY, MEM_WRITE, FWD_HIT, LOAD_STALL}, 8'b000_1_1_0_0_0);
        check("reset_bus", {MEM_ADDR, MEM_WRITEDATA, MEM_MASK}, 0);
        repeat (2) @(negedge CLK);
        #3 RESET = 1'b1;

        // basic forward of a full-mask store
        step(1, 32'h1000, 32'hDEADBEEF, 4'hF, 0, 0, 1);
        step(0, 0, 0, 0, 1, 32'h1000, 1);
        check("head_addr", MEM_ADDR, 32'h1000);
        // newest of two matches wins
        step(1, 32'h2000, 32'h11111111, 4'hF, 0, 0, 1);
        step(1, 32'h2000, 32'h22222222, 4'hF, 1, 32'h2002, 1);
        step(0, 0, 0, 0, 1, 32'h2002, 1);
        repeat (4) step(0, 0, 0, 0, 0, 0, 0);
        // partial overlap stalls until the entry retires
        step(1, 32'h3000, 32'h0000CCCC, 4'b0011, 0, 0, 1);
        step(0, 0, 0, 0, 1, 32'h3000, 1);
        step(0, 0, 0, 0, 1, 32'h3000, 0);
        step(0, 0, 0, 0, 1, 32'h3000, 1);
        // fill, then blocked store with a retire on the same edge, then wrap
        for (int i = 0; i < DEPTH; i++) step(1, 32'h5000 + 4*i, 32'h50 + i, 4'hF, 0, 0, 1);
        step(1, 32'h6000, 32'h60, 4'hF, 0, 0, 0);
        step(0, 0, 0, 0, 1, 32'h5004, 1);
        for (int i = 0; i < 6; i++) step(1, 32'h6100 + 4*i, 32'h61 + i, 4'hF, 0, 0, 0);
        repeat (DEPTH + 1) step(0, 0, 0, 0, 0, 0, 0);
        // reset while draining three entries
        for (int i = 0; i < DEPTH; i++) step(1, 32'h8000 + 4*i, 32'h80 + i, 4'hF, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0);
        reset_mid();
        step(0, 0, 0, 0, 1, 32'h8004, 1);
        // two partial stores to one word behind a busy head
        step(1, 32'h7000, 32'h70, 4'hF, 0, 0, 1);
        step(1, 32'h4000, 32'h0000AAAA, 4'b0011, 0, 0, 1);
        step(1, 32'h4000, 32'hBBBB0000, 4'b1100, 0, 0, 1);
        step(0, 0, 0, 0, 1, 32'h4000, 1);
        repeat (DEPTH + 1) step(0, 0, 0, 0, 0, 0, 0);

        // random traffic over a small address pool to force matches and merges
        for (int i = 0; i < 400; i++) begin
            a = 32'h100 + 4 * $urandom_range(0, 3);
            step($urandom_range(0, 2) != 0, a, $urandom,
                 ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom_range(1, 14)),
                 $urandom_range(0, 1) != 0, 32'h100 + $urandom_range(0, 15),
                 $urandom_range(0, 2) == 0);
        end
        repeat (DEPTH + 2) step(0, 0, 0, 0, 0, 0, 0);
        check("drained", mem_exp_q.size(), 0);
        check("loads_consumed", ld_exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
